// File: rtl/picosoc_ram_arbiter.sv
// Round-robin arbiter sharing the single-port soc_mem RAM between two native-bus masters.
// Every access takes one issue cycle (IDLE) and one response cycle (RESP).
module picosoc_ram_arbiter #(
  parameter int MEM_WORDS = 4096,
  parameter int ABITS     = 12
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_valid,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [3:0]       m0_wstrb,
  output logic             m0_ready,
  output logic [31:0]      m0_rdata,
  input  logic             m1_valid,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  input  logic [3:0]       m1_wstrb,
  output logic             m1_ready,
  output logic [31:0]      m1_rdata,
  output logic [ABITS-1:0] ram_addr,
  output logic [3:0]       ram_byteena,
  output logic             ram_wren,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_q,
  output logic [15:0]      contention
);

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] contention_q, contention_d;

  logic        sel;
  logic        issue;
  logic        issue_ok;
  logic        contend;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  always_comb begin
    sel          = 1'b0;
    issue        = 1'b0;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (m0_valid && m1_valid) begin
      sel = ~last_grant_q;
    end else if (m1_valid) begin
      sel = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          issue        = 1'b1;
          state_d      = RESP;
          grant_d      = sel;
          last_grant_d = sel;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port is only driven during the issue cycle; reset also blocks it so nothing is written while held.
  assign issue_ok  = issue && resetn;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_wstrb = sel ? m1_wstrb : m0_wstrb;

  assign ram_addr    = issue_ok ? sel_addr[ABITS+1:2] : '0;
  assign ram_wdata   = issue_ok ? sel_wdata : 32'h0;
  assign ram_byteena = issue_ok ? sel_wstrb : 4'h0;
  assign ram_wren    = issue_ok && (|sel_wstrb);

  assign m0_ready = (state_q == RESP) && !grant_q;
  assign m1_ready = (state_q == RESP) &&  grant_q;
  assign m0_rdata = grant_q ? 32'h0 : ram_q;
  assign m1_rdata = grant_q ? ram_q : 32'h0;

  // A stall cycle is a tie in IDLE or the losing master waiting through RESP.
  assign contend = ((state_q == IDLE) && m0_valid && m1_valid) ||
                   ((state_q == RESP) && (grant_q ? m0_valid : m1_valid));

  always_comb begin
    contention_d = contention_q;
    if (contend && (contention_q != 16'hFFFF)) begin
      contention_d = contention_q + 16'd1;
    end
  end

  assign contention = contention_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      contention_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      contention_q <= contention_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{m0_addr[31:ABITS+2], m0_addr[1:0],
                         m1_addr[31:ABITS+2], m1_addr[1:0]};

endmodule

// File: tb/tb_picosoc_ram_arbiter.sv
// Directed bench for picosoc_ram_arbiter with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps
module tb_picosoc_ram_arbiter;

  localparam int ABITS = 12;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0]      m0_addr = '0, m1_addr = '0;
  logic [31:0]      m0_wdata = '0, m1_wdata = '0;
  logic [3:0]       m0_wstrb = '0, m1_wstrb = '0;
  logic             m0_ready, m1_ready;
  logic [31:0]      m0_rdata, m1_rdata;
  logic [ABITS-1:0] ram_addr;
  logic [3:0]       ram_byteena;
  logic             ram_wren;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_q = '0;
  logic [15:0]      contention;

  logic [31:0] mem [0:(1<<ABITS)-1];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  picosoc_ram_arbiter #(.MEM_WORDS(4096), .ABITS(ABITS)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_byteena(ram_byteena), .ram_wren(ram_wren),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .contention(contention)
  );

  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteena[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    m0_valid = 0; m1_valid = 0; m0_wstrb = 0; m1_wstrb = 0;
    resetn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1;
    step();
  endtask

  task automatic test_reset();
    resetn = 0;
    m0_valid = 1; m0_addr = 32'h40; m0_wstrb = 4'hF; m0_wdata = 32'hCAFEF00D;
    #2;
    chk("reset_m0_ready", {31'b0, m0_ready}, 0);
    chk("reset_m1_ready", {31'b0, m1_ready}, 0);
    chk("reset_ram_wren", {31'b0, ram_wren}, 0);
    chk("reset_ram_byteena", {28'b0, ram_byteena}, 0);
    chk("reset_ram_addr", {20'b0, ram_addr}, 0);
    chk("reset_ram_wdata", ram_wdata, 0);
    chk("reset_contention", {16'b0, contention}, 0);
    m0_valid = 0; m0_wstrb = 0;
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    mem[5] = 32'hDEADBEEF;
    m0_valid = 1; m0_addr = 32'h14; m0_wstrb = 0;
    #1;
    chk("read_ram_addr", {20'b0, ram_addr}, 5);
    chk("read_ram_wren", {31'b0, ram_wren}, 0);
    chk("read_issue_no_ready", {31'b0, m0_ready}, 0);
    step();
    chk("read_m0_ready", {31'b0, m0_ready}, 1);
    chk("read_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("read_m1_ready", {31'b0, m1_ready}, 0);
    chk("read_m1_rdata", m1_rdata, 0);
    m0_valid = 0;
    step();
    chk("read_ready_pulse", {31'b0, m0_ready}, 0);
    chk("read_contention", {16'b0, contention}, 0);
    $display("test_single_read m0 rdata=%h", 32'hDEADBEEF);
  endtask

  task automatic test_byte_write();
    mem[8] = 32'h11223344;
    m1_valid = 1; m1_addr = 32'h20; m1_wstrb = 4'b0010; m1_wdata = 32'h0000AB00;
    #1;
    chk("bw_ram_byteena", {28'b0, ram_byteena}, 4'b0010);
    chk("bw_ram_wren", {31'b0, ram_wren}, 1);
    chk("bw_ram_addr", {20'b0, ram_addr}, 8);
    step();
    chk("bw_m1_ready", {31'b0, m1_ready}, 1);
    chk("bw_resp_byteena", {28'b0, ram_byteena}, 0);
    chk("bw_resp_wren", {31'b0, ram_wren}, 0);
    m1_valid = 0; m1_wstrb = 0;
    step();
    m0_valid = 1; m0_addr = 32'h20; m0_wstrb = 0;
    step();
    chk("bw_readback_ready", {31'b0, m0_ready}, 1);
    chk("bw_readback", m0_rdata, 32'h1122AB44);
    m0_valid = 0;
    step();
    $display("test_byte_write word8=%h", 32'h1122AB44);
  endtask

  task automatic test_first_tie();
    do_reset();
    mem[16] = 32'hA0A0A0A0; mem[17] = 32'hB1B1B1B1;
    m0_valid = 1; m0_addr = 32'h40; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'h44; m1_wstrb = 0;
    #1;
    chk("tie_first_addr", {20'b0, ram_addr}, 16);
    step();
    chk("tie_m0_ready", {31'b0, m0_ready}, 1);
    chk("tie_m1_wait", {31'b0, m1_ready}, 0);
    chk("tie_m0_rdata", m0_rdata, 32'hA0A0A0A0);
    m0_valid = 0;
    step();
    chk("tie_second_addr", {20'b0, ram_addr}, 17);
    step();
    chk("tie_m1_ready", {31'b0, m1_ready}, 1);
    chk("tie_m1_rdata", m1_rdata, 32'hB1B1B1B1);
    m1_valid = 0;
    step();
    chk("tie_contention", {16'b0, contention}, 2);
    $display("test_first_tie order 0,1 contention=%0d", contention);
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0, prev = -1, both = 0, alt_err = 0;
    do_reset();
    m0_valid = 1; m0_addr = 32'h0; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'h4; m1_wstrb = 0;
    for (int c = 0; c < 20; c++) begin
      if (m0_ready && m1_ready) both++;
      if (m0_ready) begin
        n0++;
        if (prev == 0) alt_err++;
        prev = 0;
      end else if (m1_ready) begin
        n1++;
        if (prev == 1) alt_err++;
        prev = 1;
      end
      step();
    end
    m0_valid = 0; m1_valid = 0;
    chk("b2b_m0_pulses", n0, 5);
    chk("b2b_m1_pulses", n1, 5);
    chk("b2b_both_ready", both, 0);
    chk("b2b_alternation", alt_err, 0);
    step();
    $display("test_back_to_back m0=%0d m1=%0d", n0, n1);
  endtask

  task automatic test_reset_in_resp();
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h80; m1_addr = 32'h84; m0_wstrb = 4'hF; m0_wdata = 32'h12345678;
    step();
    chk("rr_pre_ready", {31'b0, m0_ready | m1_ready}, 1);
    chk("rr_pre_contention_nz", {31'b0, contention != 0}, 1);
    #2 resetn = 0;
    #1;
    chk("rr_m0_ready_drop", {31'b0, m0_ready}, 0);
    chk("rr_m1_ready_drop", {31'b0, m1_ready}, 0);
    chk("rr_wren_drop", {31'b0, ram_wren}, 0);
    chk("rr_contention_clr", {16'b0, contention}, 0);
    m0_valid = 0; m1_valid = 0; m0_wstrb = 0;
    @(posedge clk);
    @(negedge clk) resetn = 1;
    step();
    chk("rr_idle_ready", {31'b0, m0_ready}, 0);
    m0_valid = 1; m0_addr = 32'h80;
    step();
    chk("rr_reissue_ready", {31'b0, m0_ready}, 1);
    chk("rr_contention_after", {16'b0, contention}, 0);
    m0_valid = 0;
    step();
    $display("test_reset_in_resp done");
  endtask

  task automatic test_saturation();
    m0_valid = 1; m1_valid = 1; m0_wstrb = 0; m1_wstrb = 0;
    repeat (70000) step();
    chk("sat_value", {16'b0, contention}, 16'hFFFF);
    repeat (4) step();
    chk("sat_hold", {16'b0, contention}, 16'hFFFF);
    m0_valid = 0; m1_valid = 0;
    step();
    $display("test_saturation contention=%h", contention);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_first_tie();
    test_back_to_back();
    test_reset_in_resp();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
